// File: rtl/ip_frame_driver.sv
// Host-side initiator for the image-filter IP: buffers an 8x8 frame, replays it, issues the mode, forwards 64 results.
// Latency: all outputs registered; a result appears on res_* one cycle after its out_valid beat.
// Backpressure: host command/pixel streams are valid/ready (ready registered); the result stream has none.
module ip_frame_driver #(
    parameter int N_PIX   = 64,
    parameter int PIX_W   = 8,
    parameter int RES_W   = 12,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic             cmd_new_img,
    input  logic             s_pix_valid,
    output logic             s_pix_ready,
    input  logic [PIX_W-1:0] s_pix_data,
    output logic             in_valid_1,
    output logic [PIX_W-1:0] in_image,
    output logic             in_valid_2,
    output logic [1:0]       in_mode,
    input  logic             out_valid,
    input  logic [RES_W-1:0] out_number,
    output logic             res_valid,
    output logic [RES_W-1:0] res_data,
    output logic [5:0]       res_index,
    output logic             res_last,
    output logic             busy,
    output logic             err_mode,
    output logic             err_timeout,
    output logic             err_proto
);

    localparam logic [5:0] LAST_IDX = 6'(N_PIX - 1);
    // WAIT is entered with the timer at 1, so timer==TIMEOUT-1 is the last cycle an out_valid is still accepted.
    localparam logic [5:0] TO_LAST  = 6'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_MODE,
        S_WAIT,
        S_RECV,
        S_COOL
    } state_t;

    state_t           state, state_nxt;
    logic [5:0]       wr_cnt, wr_cnt_nxt;
    logic [5:0]       send_cnt, send_cnt_nxt;
    logic [5:0]       rd_cnt, rd_cnt_nxt;
    logic [5:0]       timer, timer_nxt;
    logic [1:0]       mode_q, mode_nxt;
    logic             img_held, img_held_nxt;
    logic             err_mode_nxt, err_timeout_nxt, err_proto_nxt;
    logic             res_valid_nxt, res_last_nxt;
    logic [RES_W-1:0] res_data_nxt;
    logic [5:0]       res_index_nxt;
    logic             in_valid_1_nxt, in_valid_2_nxt;
    logic [PIX_W-1:0] in_image_nxt;
    logic [1:0]       in_mode_nxt;
    logic             cmd_acc, pix_acc, pix_wr;

    logic [PIX_W-1:0] pix_buf [N_PIX];

    assign cmd_acc = cmd_valid & cmd_ready;
    assign pix_acc = s_pix_valid & s_pix_ready;

    // Next-state, counter, flag and output computation; outputs are registered from the next state.
    always_comb begin
        state_nxt       = state;
        wr_cnt_nxt      = wr_cnt;
        send_cnt_nxt    = send_cnt;
        rd_cnt_nxt      = rd_cnt;
        timer_nxt       = timer;
        mode_nxt        = mode_q;
        img_held_nxt    = img_held;
        err_mode_nxt    = err_mode;
        err_timeout_nxt = err_timeout;
        err_proto_nxt   = err_proto;
        res_valid_nxt   = 1'b0;
        res_data_nxt    = '0;
        res_index_nxt   = '0;
        res_last_nxt    = 1'b0;
        pix_wr          = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_acc) begin
                    mode_nxt = cmd_mode;
                    if (cmd_mode == 2'd3) begin
                        err_mode_nxt = 1'b1;
                    end else if (cmd_new_img || !img_held) begin
                        state_nxt  = S_LOAD;
                        wr_cnt_nxt = '0;
                    end else begin
                        state_nxt = S_MODE;
                    end
                end
            end
            S_LOAD: begin
                if (pix_acc) begin
                    pix_wr = 1'b1;
                    if (wr_cnt == LAST_IDX) begin
                        state_nxt    = S_SEND;
                        wr_cnt_nxt   = '0;
                        send_cnt_nxt = '0;
                    end else begin
                        wr_cnt_nxt = wr_cnt + 6'd1;
                    end
                end
            end
            S_SEND: begin
                if (send_cnt == LAST_IDX) begin
                    state_nxt    = S_MODE;
                    send_cnt_nxt = '0;
                    img_held_nxt = 1'b1;
                end else begin
                    send_cnt_nxt = send_cnt + 6'd1;
                end
            end
            S_MODE: begin
                state_nxt  = S_WAIT;
                timer_nxt  = 6'd1;
                rd_cnt_nxt = '0;
            end
            S_WAIT: begin
                if (out_valid) begin
                    state_nxt  = S_RECV;
                    rd_cnt_nxt = 6'd1;
                    timer_nxt  = '0;
                end else if (timer == TO_LAST) begin
                    state_nxt       = S_IDLE;
                    err_timeout_nxt = 1'b1;
                    timer_nxt       = '0;
                end else begin
                    timer_nxt = timer + 6'd1;
                end
            end
            S_RECV: begin
                if (out_valid) begin
                    if (rd_cnt == LAST_IDX) begin
                        state_nxt  = S_COOL;
                        rd_cnt_nxt = '0;
                    end else begin
                        rd_cnt_nxt = rd_cnt + 6'd1;
                    end
                end else begin
                    // A gap mid-frame abandons the frame; the partial result set is not padded out.
                    state_nxt     = S_IDLE;
                    err_proto_nxt = 1'b1;
                    rd_cnt_nxt    = '0;
                end
            end
            S_COOL: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Result beats are forwarded from WAIT (beat 0) and RECV; COOL swallows any IP tail.
        if ((state == S_WAIT || state == S_RECV) && out_valid) begin
            res_valid_nxt = 1'b1;
            res_data_nxt  = out_number;
            res_index_nxt = rd_cnt;
            res_last_nxt  = (rd_cnt == LAST_IDX);
        end
        if ((state == S_IDLE || state == S_LOAD || state == S_SEND || state == S_MODE) && out_valid) begin
            err_proto_nxt = 1'b1;
        end

        in_valid_1_nxt = (state_nxt == S_SEND);
        in_image_nxt   = in_valid_1_nxt ? pix_buf[send_cnt_nxt] : '0;
        in_valid_2_nxt = (state_nxt == S_MODE);
        in_mode_nxt    = in_valid_2_nxt ? mode_nxt : 2'd0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters, held-frame flag, sticky errors and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt      <= '0;
            send_cnt    <= '0;
            rd_cnt      <= '0;
            timer       <= '0;
            mode_q      <= '0;
            img_held    <= 1'b0;
            err_mode    <= 1'b0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_index   <= '0;
            res_last    <= 1'b0;
            in_valid_1  <= 1'b0;
            in_image    <= '0;
            in_valid_2  <= 1'b0;
            in_mode     <= '0;
            cmd_ready   <= 1'b0;
            s_pix_ready <= 1'b0;
            busy        <= 1'b0;
        end else begin
            wr_cnt      <= wr_cnt_nxt;
            send_cnt    <= send_cnt_nxt;
            rd_cnt      <= rd_cnt_nxt;
            timer       <= timer_nxt;
            mode_q      <= mode_nxt;
            img_held    <= img_held_nxt;
            err_mode    <= err_mode_nxt;
            err_timeout <= err_timeout_nxt;
            err_proto   <= err_proto_nxt;
            res_valid   <= res_valid_nxt;
            res_data    <= res_data_nxt;
            res_index   <= res_index_nxt;
            res_last    <= res_last_nxt;
            in_valid_1  <= in_valid_1_nxt;
            in_image    <= in_image_nxt;
            in_valid_2  <= in_valid_2_nxt;
            in_mode     <= in_mode_nxt;
            cmd_ready   <= (state_nxt == S_IDLE);
            s_pix_ready <= (state_nxt == S_LOAD);
            busy        <= (state_nxt != S_IDLE);
        end
    end

    // Frame buffer write; storage only, so no reset.
    always_ff @(posedge clk) begin
        if (pix_wr) begin
            pix_buf[wr_cnt] <= s_pix_data;
        end
    end

endmodule

// File: tb/tb_ip_frame_driver.sv
// Self-checking bench for ip_frame_driver with a behavioural filter-IP model and result scoreboard.
// Latency: expects results one cycle after each out_valid beat, in_valid_2 right after the last pixel.
// Backpressure: host pixel stream is stalled in one scenario; result stream is never stalled.
module tb_ip_frame_driver;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic        cmd_new_img;
    logic        s_pix_valid;
    logic        s_pix_ready;
    logic [7:0]  s_pix_data;
    logic        in_valid_1;
    logic [7:0]  in_image;
    logic        in_valid_2;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic [11:0] out_number;
    logic        res_valid;
    logic [11:0] res_data;
    logic [5:0]  res_index;
    logic        res_last;
    logic        busy;
    logic        err_mode;
    logic        err_timeout;
    logic        err_proto;

    typedef struct packed {
        logic [11:0] data;
        logic [5:0]  idx;
        logic        last;
    } res_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] pix_q[$];
    res_t       res_q[$];
    logic [7:0] ip_img [64];

    ip_frame_driver dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mode    (cmd_mode),
        .cmd_new_img (cmd_new_img),
        .s_pix_valid (s_pix_valid),
        .s_pix_ready (s_pix_ready),
        .s_pix_data  (s_pix_data),
        .in_valid_1  (in_valid_1),
        .in_image    (in_image),
        .in_valid_2  (in_valid_2),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_number  (out_number),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_index   (res_index),
        .res_last    (res_last),
        .busy        (busy),
        .err_mode    (err_mode),
        .err_timeout (err_timeout),
        .err_proto   (err_proto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [7:0] pix_of(input int sel, input int k);
        case (sel)
            0:       return 8'(k);
            1:       return 8'(k * 37 + 11);
            default: return 8'(k ^ 8'hA5);
        endcase
    endfunction

    // Synthetic IP output: depends on mode, stored pixel and position.
    function automatic logic [11:0] ip_calc(input int m, input int i);
        return 12'(int'(ip_img[i]) * (m + 1) + i * 7);
    endfunction

    task automatic send_cmd(input logic [1:0] mode, input logic new_img);
        int guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b want 1", cmd_ready);
        end
        cmd_valid   = 1'b1;
        cmd_mode    = mode;
        cmd_new_img = new_img;
        step();
        cmd_valid   = 1'b0;
        cmd_mode    = 2'd0;
        cmd_new_img = 1'b0;
    endtask

    task automatic load_frame(input int sel, input bit stall);
        int k = 0;
        int guard = 0;
        bit ph = 1'b0;
        while (k < 64 && guard < 400) begin
            if (stall && ph) begin
                s_pix_valid = 1'b0;
            end else begin
                s_pix_valid = 1'b1;
                s_pix_data  = pix_of(sel, k);
                if (s_pix_ready === 1'b1) begin
                    pix_q.push_back(s_pix_data);
                    k++;
                end
            end
            ph = !ph;
            guard++;
            step();
        end
        s_pix_valid = 1'b0;
        s_pix_data  = 8'd0;
        checks++;
        if (k != 64) begin
            errors++;
            $display("FAIL load_count: accepted %0d pixels want 64", k);
        end
    endtask

    task automatic check_send(input logic [1:0] exp_mode);
        logic [7:0] e;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (in_valid_1 !== 1'b1 || in_valid_2 !== 1'b0) begin
                errors++;
                $display("FAIL send_valid[%0d]: in_valid_1=%b in_valid_2=%b want 1/0", i, in_valid_1, in_valid_2);
            end
            checks++;
            if (pix_q.size() == 0) begin
                errors++;
                $display("FAIL send_data[%0d]: got %0d, no pixel expected", i, in_image);
            end else begin
                e = pix_q.pop_front();
                if (in_image !== e) begin
                    errors++;
                    $display("FAIL send_data[%0d]: got %0d want %0d", i, in_image, e);
                end
            end
            ip_img[i] = in_image;
            step();
        end
        checks++;
        if (in_valid_1 !== 1'b0 || in_valid_2 !== 1'b1 || in_mode !== exp_mode) begin
            errors++;
            $display("FAIL mode_issue: in_valid_1=%b in_valid_2=%b in_mode=%0d want 0/1/%0d",
                     in_valid_1, in_valid_2, in_mode, exp_mode);
        end
    endtask

    // Call at the in_valid_2 cycle; acts as the IP and scoreboards the forwarded results.
    task automatic ip_respond(input int mode, input int lat, input int nb,
                              output int nlast, output int last_idx);
        int   beat = 0;
        res_t e;
        nlast    = 0;
        last_idx = -1;
        for (int cyc = 0; cyc <= lat + nb; cyc++) begin
            checks++;
            if (res_q.size() != 0) begin
                e = res_q.pop_front();
                if (res_valid !== 1'b1 || res_data !== e.data || res_index !== e.idx || res_last !== e.last) begin
                    errors++;
                    $display("FAIL result[%0d]: vld=%b data=%0d idx=%0d last=%b want 1/%0d/%0d/%b",
                             e.idx, res_valid, res_data, res_index, res_last, e.data, e.idx, e.last);
                end
            end else if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL result_spurious: res_valid=%b idx=%0d want 0", res_valid, res_index);
            end
            if (res_valid === 1'b1) begin
                last_idx = int'(res_index);
                if (res_last === 1'b1) nlast++;
            end
            if (cyc > 0) begin
                checks++;
                if (in_valid_1 !== 1'b0 || in_valid_2 !== 1'b0) begin
                    errors++;
                    $display("FAIL ip_quiet: in_valid_1=%b in_valid_2=%b want 0/0", in_valid_1, in_valid_2);
                end
            end
            if (cyc >= lat && beat < nb) begin
                out_valid  = 1'b1;
                out_number = ip_calc(mode, beat);
                e.data = out_number;
                e.idx  = 6'(beat);
                e.last = (beat == 63);
                res_q.push_back(e);
                beat++;
            end else begin
                out_valid  = 1'b0;
                out_number = 12'd0;
            end
            step();
        end
        out_valid  = 1'b0;
        out_number = 12'd0;
        checks++;
        if (res_q.size() != 0) begin
            errors++;
            $display("FAIL result_missing: %0d results outstanding want 0", res_q.size());
            res_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({cmd_ready, s_pix_ready, in_valid_1, in_image, in_valid_2, in_mode, res_valid, res_data,
             res_index, res_last, busy, err_mode, err_timeout, err_proto} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b pix_rdy=%b v1=%b v2=%b res=%b busy=%b errs=%b%b%b want all 0",
                     cmd_ready, s_pix_ready, in_valid_1, in_valid_2, res_valid, busy, err_mode, err_timeout, err_proto);
        end
        rst = 1'b0;
        step();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: cmd_ready=%b busy=%b want 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_new_frame();
        int nl, li;
        send_cmd(2'd0, 1'b1);
        checks++;
        if (s_pix_ready !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_enter: s_pix_ready=%b busy=%b cmd_ready=%b want 1/1/0", s_pix_ready, busy, cmd_ready);
        end
        load_frame(0, 1'b0);
        check_send(2'd0);
        ip_respond(0, 3, 64, nl, li);
        checks++;
        if (nl != 1 || li != 63) begin
            errors++;
            $display("FAIL frame_last: res_last count %0d last idx %0d want 1/63", nl, li);
        end
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || err_proto !== 1'b0) begin
            errors++;
            $display("FAIL frame_done: busy=%b cmd_ready=%b err_proto=%b want 0/1/0", busy, cmd_ready, err_proto);
        end
    endtask

    task automatic test_host_stall();
        int nl, li;
        send_cmd(2'd2, 1'b1);
        load_frame(1, 1'b1);
        check_send(2'd2);
        ip_respond(2, 1, 64, nl, li);
        checks++;
        if (nl != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: res_last count %0d busy=%b want 1/0", nl, busy);
        end
    endtask

    task automatic test_reuse();
        int nl, li;
        send_cmd(2'd1, 1'b0);
        checks++;
        if (in_valid_1 !== 1'b0 || in_valid_2 !== 1'b1 || in_mode !== 2'd1 || s_pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL reuse_mode: v1=%b v2=%b mode=%0d pix_rdy=%b want 0/1/1/0",
                     in_valid_1, in_valid_2, in_mode, s_pix_ready);
        end
        ip_respond(1, 5, 64, nl, li);
        checks++;
        if (nl != 1 || li != 63) begin
            errors++;
            $display("FAIL reuse_last: res_last count %0d last idx %0d want 1/63", nl, li);
        end
    endtask

    task automatic test_mode_err();
        checks++;
        if (err_mode !== 1'b0) begin
            errors++;
            $display("FAIL mode_err_pre: err_mode=%b want 0", err_mode);
        end
        send_cmd(2'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (err_mode !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 ||
                in_valid_1 !== 1'b0 || in_valid_2 !== 1'b0 || s_pix_ready !== 1'b0) begin
                errors++;
                $display("FAIL mode_err[%0d]: err_mode=%b ready=%b busy=%b v1=%b v2=%b pix_rdy=%b want 1/1/0/0/0/0",
                         i, err_mode, cmd_ready, busy, in_valid_1, in_valid_2, s_pix_ready);
            end
            step();
        end
    endtask

    task automatic test_timeout();
        send_cmd(2'd2, 1'b0);
        checks++;
        if (in_valid_2 !== 1'b1 || in_mode !== 2'd2) begin
            errors++;
            $display("FAIL to_mode: in_valid_2=%b in_mode=%0d want 1/2", in_valid_2, in_mode);
        end
        for (int i = 1; i <= 15; i++) step();
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_early: err_timeout=%b busy=%b at +15 want 0/1", err_timeout, busy);
        end
        step();
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_fire: err_timeout=%b busy=%b ready=%b res_valid=%b at +16 want 1/0/1/0",
                     err_timeout, busy, cmd_ready, res_valid);
        end
    endtask

    task automatic test_drop_and_reset();
        int nl, li;
        checks++;
        if (err_proto !== 1'b0) begin
            errors++;
            $display("FAIL drop_pre: err_proto=%b want 0", err_proto);
        end
        send_cmd(2'd0, 1'b0);
        ip_respond(0, 2, 10, nl, li);
        checks++;
        if (err_proto !== 1'b1 || li != 9 || nl != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop: err_proto=%b last idx %0d res_last count %0d busy=%b want 1/9/0/0",
                     err_proto, li, nl, busy);
        end
        // Reset in the middle of SEND, then a reuse request must reload.
        send_cmd(2'd1, 1'b1);
        load_frame(2, 1'b0);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (in_valid_1 !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: in_valid_1=%b want 1", in_valid_1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        pix_q.delete();
        checks++;
        if (in_valid_1 !== 1'b0 || busy !== 1'b0 || err_proto !== 1'b0 || err_mode !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: in_valid_1=%b busy=%b err_proto=%b err_mode=%b want 0/0/0/0",
                     in_valid_1, busy, err_proto, err_mode);
        end
        send_cmd(2'd2, 1'b0);
        checks++;
        if (s_pix_ready !== 1'b1 || in_valid_2 !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL forced_load: s_pix_ready=%b in_valid_2=%b busy=%b want 1/0/1", s_pix_ready, in_valid_2, busy);
        end
        load_frame(0, 1'b0);
        check_send(2'd2);
        ip_respond(2, 4, 64, nl, li);
        checks++;
        if (nl != 1 || li != 63 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reload_done: res_last count %0d last idx %0d busy=%b want 1/63/0", nl, li, busy);
        end
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_mode    = 2'd0;
        cmd_new_img = 1'b0;
        s_pix_valid = 1'b0;
        s_pix_data  = 8'd0;
        out_valid   = 1'b0;
        out_number  = 12'd0;
        step();
        test_reset();
        test_new_frame();
        test_host_stall();
        test_reuse();
        test_mode_err();
        test_timeout();
        test_drop_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
